id_ex_stage_buf: RTL and testbench

- Parametrised, multi-lane ID->EX pipeline stage for the superscalar core. Replaces the fixed single-issue ID/EX register.
- Carries LANES instruction slots, each with an opaque control field and a data payload.
- Adds a valid/ready handshake backed by a 2-entry skid buffer, so in_ready is a registered signal. Also adds synchronous flush and per-lane bubble kill.
- Sits between issue/decode and the execute lanes.

---
 rtl/id_ex_stage_buf.sv | 124 ++++++++++++
 tb/tb_id_ex_stage_buf.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_buf.sv
// id_ex_stage_buf: multi-lane ID->EX stage with valid/ready handshake, 2-entry skid buffer, flush and bubble kill.
// Define ID_EX_PERF_EN to add saturating stall_cycles / flush_count counters.
module id_ex_stage_buf #(
  parameter int LANES  = 2,
  parameter int CTRL_W = 16,
  parameter int DATA_W = 112
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_lane_vld,
  input  logic [LANES*CTRL_W-1:0]   in_ctrl,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_lane_vld,
  output logic [LANES*CTRL_W-1:0]   out_ctrl,
  output logic [LANES*DATA_W-1:0]   out_data
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [15:0]               flush_count
`endif
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  state_t state_q, state_d;
  logic [LANES-1:0]        m_lv_q, m_lv_d, s_lv_q, s_lv_d;
  logic [LANES*CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d, in_ctrl_m;
  logic [LANES*DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic accept, consume;
  assign in_ready  = state_q != SKID;
  assign out_valid = state_q != EMPTY;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign out_lane_vld = out_valid ? m_lv_q : '0;
  assign out_ctrl     = out_valid ? m_ctrl_q : '0;
  assign out_data     = m_data_q;
  // dead slots never carry control bits into execute
  always_comb begin
    in_ctrl_m = in_ctrl;
    for (int i = 0; i < LANES; i++)
      if (!in_lane_vld[i]) in_ctrl_m[i*CTRL_W +: CTRL_W] = '0;
  end
  always_comb begin
    state_d  = state_q;
    m_lv_d   = m_lv_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_lv_d   = s_lv_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (flush) begin
      state_d  = EMPTY;
      m_lv_d   = '0;
      m_ctrl_d = '0;
      s_lv_d   = '0;
      s_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d  = FULL;
          m_lv_d   = in_lane_vld;
          m_ctrl_d = in_ctrl_m;
          m_data_d = in_data;
        end
        FULL: if (accept && !consume) begin
          state_d  = SKID;
          s_lv_d   = in_lane_vld;
          s_ctrl_d = in_ctrl_m;
          s_data_d = in_data;
        end else if (accept) begin
          m_lv_d   = in_lane_vld;
          m_ctrl_d = in_ctrl_m;
          m_data_d = in_data;
        end else if (consume) begin
          state_d = EMPTY;
        end
        SKID: if (consume) begin
          state_d  = FULL;
          m_lv_d   = s_lv_q;
          m_ctrl_d = s_ctrl_q;
          m_data_d = s_data_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= EMPTY;
      m_lv_q   <= '0;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_lv_q   <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      m_lv_q   <= m_lv_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_lv_q   <= s_lv_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
    end
  end
`ifdef ID_EX_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_q)) stall_q <= stall_q + 32'd1;
      if (flush && !(&flush_q)) flush_q <= flush_q + 16'd1;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif
endmodule

// File: tb/tb_id_ex_stage_buf.sv
// tb_id_ex_stage_buf: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_id_ex_stage_buf;
  localparam int L = 2, CW = 16, DW = 112;
  localparam int TW = L*CW, DTW = L*DW;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [L-1:0] in_lane_vld = '0, out_lane_vld;
  logic [TW-1:0] in_ctrl = '0, out_ctrl;
  logic [DTW-1:0] in_data = '0, out_data;
`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  id_ex_stage_buf #(.LANES(L), .CTRL_W(CW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_vld(out_lane_vld), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef ID_EX_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );
  typedef struct {logic [L-1:0] lv; logic [TW-1:0] c; logic [DTW-1:0] d;} ent_t;
  ent_t q[$];
  logic [DTW-1:0] last_d = '0;
  task automatic chk(input string name, input logic [DTW-1:0] act, input logic [DTW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [TW-1:0] live_mask(input logic [L-1:0] lv);
    logic [TW-1:0] m = '0;
    for (int i = 0; i < L; i++) if (lv[i]) m |= {{(TW-CW){1'b0}}, {CW{1'b1}}} << (i*CW);
    return m;
  endfunction
  task automatic check_model();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("lane_vld", out_lane_vld, q[0].lv);
      chk("ctrl", out_ctrl, q[0].c);
      chk("data", out_data, q[0].d);
    end else begin
      chk("lane_vld_idle", out_lane_vld, 0);
      chk("ctrl_idle", out_ctrl, 0);
      chk("data_held", out_data, last_d);
    end
  endtask
  task automatic cycle(input logic v, input logic [L-1:0] lv, input logic [TW-1:0] c,
                       input logic [DTW-1:0] d, input logic fl, input logic r);
    logic acc, cons;
    check_model();
    in_valid = v; in_lane_vld = lv; in_ctrl = c; in_data = d; flush = fl; out_ready = r;
    acc  = v && q.size() < 2;
    cons = r && q.size() > 0;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back('{lv, c & live_mask(lv), d});
    end
    if (q.size() > 0) last_d = q[0].d;
    @(negedge clk);
  endtask
  typedef struct {
    logic v; logic [L-1:0] lv; logic [TW-1:0] c; logic [DTW-1:0] d; logic fl, r;
    logic eov, eir; logic [L-1:0] elv; logic [TW-1:0] ec; logic [DTW-1:0] ed;
  } vec_t;
  vec_t tv[12];
  logic [DTW-1:0] bd, rd;
  initial begin
    bd = {112'h77, 112'h88};
    tv[0]  = '{1, 2'b11, 32'h1111_2222, 224'd1,  0, 0, 1, 1, 2'b11, 32'h1111_2222, 224'd1};
    tv[1]  = '{1, 2'b11, 32'h3333_4444, 224'd2,  0, 0, 1, 0, 2'b11, 32'h1111_2222, 224'd1};
    tv[2]  = '{1, 2'b11, 32'h5555_6666, 224'd3,  0, 0, 1, 0, 2'b11, 32'h1111_2222, 224'd1};
    tv[3]  = '{1, 2'b11, 32'h5555_6666, 224'd3,  0, 1, 1, 1, 2'b11, 32'h3333_4444, 224'd2};
    tv[4]  = '{1, 2'b11, 32'h5555_6666, 224'd3,  0, 1, 1, 1, 2'b11, 32'h5555_6666, 224'd3};
    tv[5]  = '{0, 2'b11, 32'h0,         224'd0,  0, 1, 0, 1, 2'b00, 32'h0,         224'd3};
    tv[6]  = '{1, 2'b01, 32'hABCD_1234, bd,      0, 0, 1, 1, 2'b01, 32'h0000_1234, bd};
    tv[7]  = '{1, 2'b00, 32'hFFFF_FFFF, 224'd9,  0, 0, 1, 0, 2'b01, 32'h0000_1234, bd};
    tv[8]  = '{1, 2'b11, 32'hFFFF_FFFF, 224'd10, 1, 0, 0, 1, 2'b00, 32'h0,         bd};
    tv[9]  = '{0, 2'b11, 32'h0,         224'd0,  0, 1, 0, 1, 2'b00, 32'h0,         bd};
    tv[10] = '{1, 2'b00, 32'hFFFF_FFFF, 224'd11, 0, 1, 1, 1, 2'b00, 32'h0,         224'd11};
    tv[11] = '{0, 2'b00, 32'h0,         224'd0,  0, 1, 0, 1, 2'b00, 32'h0,         224'd11};
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", out_data, 0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      cycle(tv[i].v, tv[i].lv, tv[i].c, tv[i].d, tv[i].fl, tv[i].r);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tv[i].eov);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tv[i].eir);
      chk($sformatf("vec%0d_lane_vld", i), out_lane_vld, tv[i].elv);
      chk($sformatf("vec%0d_ctrl", i), out_ctrl, tv[i].ec);
      chk($sformatf("vec%0d_data", i), out_data, tv[i].ed);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1, 2'b11, $urandom, DTW'(i), 0, 1);
      chk($sformatf("stream%0d_valid", i), out_valid, 1);
      chk($sformatf("stream%0d_data", i), out_data, DTW'(i));
    end
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 2'b11, 32'hFFFF_FFFF, 224'hA5, 0, 0);
    cycle(1, 2'b11, 32'hFFFF_FFFF, 224'h5A, 0, 0);
    chk("skid_in_ready", in_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_ctrl", out_ctrl, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    q.delete();
    last_d = '0;
    in_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_in_ready", in_ready, 1);
    for (int i = 0; i < 300; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cycle($urandom_range(0, 3) != 0, L'($urandom), $urandom, rd,
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end
    check_model();
`ifdef ID_EX_PERF_EN
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    last_d = '0;
    cycle(1, 2'b11, 32'h1, 224'h1, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 1, 0);
    chk("stall_cycles", stall_cycles, 5);
    chk("flush_count", flush_count, 2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
